// File: rtl/spi_pkg.sv
// Shared SPI definitions: flash command opcodes, the spi_host frame state
// encoding and the frame byte lookup used by spi_host.
package spi_pkg;

    localparam logic [7:0] CMD_READ_ID        = 8'h90;
    localparam logic [7:0] CMD_READ_STATUS    = 8'h05;
    localparam logic [7:0] CMD_WRITE_STATUS   = 8'h01;
    localparam logic [7:0] CMD_READ           = 8'h0B;
    localparam logic [7:0] CMD_WRITE          = 8'h02;
    localparam logic [7:0] CMD_POWERDOWN      = 8'hB9;
    localparam logic [7:0] CMD_EXIT_POWERDOWN = 8'hAB;
    localparam logic [7:0] CMD_ARM_RESET      = 8'h66;
    localparam logic [7:0] CMD_FIRE_RESET     = 8'h99;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } spi_state_e;

    // Byte idx of a frame; reads pad the dummy and data bytes with zeros,
    // and anything past the frame end is zero so mosi settles low.
    function automatic logic [7:0] frame_byte(input logic        we,
                                              input logic [23:0] adr,
                                              input logic [31:0] dat,
                                              input logic [3:0]  idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = we ? CMD_WRITE : CMD_READ;
            4'd1:    b = adr[23:16];
            4'd2:    b = adr[15:8];
            4'd3:    b = adr[7:0];
            4'd4:    b = we ? dat[31:24] : 8'h00;
            4'd5:    b = we ? dat[23:16] : 8'h00;
            4'd6:    b = we ? dat[15:8]  : 8'h00;
            4'd7:    b = we ? dat[7:0]   : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_host_shifter.sv
// SCK divider, 8-bit transmit/receive shift registers and bit counter.
// Mode 0: miso sampled as sck rises, next mosi bit shifted out as sck falls.
module spi_host_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       shift,
    input  logic       ld,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       tick,
    output logic       rx_last,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] rx_q, rx_d;
    logic [2:0] bit_q, bit_d;

    assign tick    = run && (div_q == 8'(CLK_DIV - 1));
    assign rx_byte = {rx_q, miso};
    assign sck     = sck_q;
    assign mosi    = tx_q[7];

    always_comb begin
        div_d     = run ? (tick ? 8'd0 : div_q + 8'd1) : 8'd0;
        sck_d     = sck_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_d     = bit_q;
        rx_last   = 1'b0;
        byte_done = 1'b0;
        if (ld) begin
            tx_d  = tx_byte;
            bit_d = 3'd0;
            sck_d = 1'b0;
        end else if (shift && tick) begin
            if (!sck_q) begin
                sck_d   = 1'b1;
                rx_d    = rx_byte[6:0];
                rx_last = (bit_q == 3'd7);
            end else begin
                sck_d = 1'b0;
                // Next byte is loaded on the 8th falling edge: bytes run back-to-back.
                if (bit_q == 3'd7) begin
                    bit_d     = 3'd0;
                    tx_d      = tx_byte;
                    byte_done = 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                    tx_d  = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sck_q <= 1'b0;
            tx_q  <= '0;
            rx_q  <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/spi_host.sv
// SPI flash host: one word read (0x0B) or write (0x02) per request, mode 0.
// Optional macro SPI_HOST_ID_CHECK_EN adds a sticky responder-ID mismatch flag.
module spi_host
    import spi_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter int         CS_GAP  = 4,
    parameter logic [7:0] EXP_ID  = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sck,
    output logic        ssn,
    output logic        mosi,
    input  logic        miso,
    input  logic        i_vld,
    output logic        o_rdy,
    input  logic        i_we,
    input  logic [23:0] i_adr,
    input  logic [31:0] i_dat,
    output logic        o_vld,
    output logic [31:0] o_dat,
    output logic        o_busy,
    output logic [7:0]  o_id,
    output logic        o_id_err
);

    spi_state_e  state_q, state_d;
    logic [3:0]  byte_q, byte_d;
    logic [7:0]  gap_q, gap_d;
    logic        we_q, we_d;
    logic [23:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [31:0] odat_q, odat_d;
    logic [7:0]  id_q, id_d;
    logic        vld_q, vld_d;
    logic        ssn_q, ssn_d;

    logic        accept, gap_last, run, shift, ld, id_upd;
    logic        tick, rx_last, byte_done;
    logic [7:0]  tx_byte, rx_byte;

    assign gap_last = (gap_q == 8'(CS_GAP - 1));
    // Ready in the last gap cycle too, so back-to-back frames keep ssn high exactly CS_GAP cycles.
    assign o_rdy    = (state_q == IDLE) || (state_q == GAP && gap_last);
    assign accept   = i_vld && o_rdy;
    assign run      = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);
    assign shift    = (state_q == SHIFT);
    assign id_upd   = rx_last && (byte_q == 4'd0);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        odat_d  = odat_q;
        id_d    = id_q;
        vld_d   = 1'b0;
        ld      = 1'b0;
        tx_byte = frame_byte(we_q, adr_q, dat_q, byte_q + 4'd1);
        case (state_q)
            IDLE:     if (accept) state_d = CS_SETUP;
            CS_SETUP: if (tick) state_d = SHIFT;
            SHIFT: begin
                if (byte_done) begin
                    if (byte_q == (we_q ? 4'd7 : 4'd8)) state_d = CS_HOLD;
                    else                                byte_d  = byte_q + 4'd1;
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_d = GAP;
                    gap_d   = 8'd0;
                    vld_d   = 1'b1;
                    if (!we_q) odat_d = rdat_q;
                end
            end
            GAP: begin
                if (gap_last) state_d = accept ? CS_SETUP : IDLE;
                else          gap_d   = gap_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            we_d    = i_we;
            adr_d   = i_adr;
            dat_d   = i_dat;
            byte_d  = 4'd0;
            ld      = 1'b1;
            tx_byte = i_we ? CMD_WRITE : CMD_READ;
        end
        // Every received byte shifts through; the last four of a read are the data word.
        if (rx_last) rdat_d = {rdat_q[23:0], rx_byte};
        if (id_upd)  id_d   = rx_byte;
        ssn_d = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            byte_q  <= '0;
            gap_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            odat_q  <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
            ssn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            odat_q  <= odat_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            ssn_q   <= ssn_d;
        end
    end

    spi_host_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .shift     (shift),
        .ld        (ld),
        .tx_byte   (tx_byte),
        .miso      (miso),
        .sck       (sck),
        .mosi      (mosi),
        .tick      (tick),
        .rx_last   (rx_last),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    assign ssn    = ssn_q;
    assign o_vld  = vld_q;
    assign o_dat  = odat_q;
    assign o_busy = !o_rdy;
    assign o_id   = id_q;

`ifdef SPI_HOST_ID_CHECK_EN
    logic id_err_q, id_err_d;

    always_comb id_err_d = id_err_q | (id_upd && (rx_byte != EXP_ID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) id_err_q <= 1'b0;
        else     id_err_q <= id_err_d;
    end

    assign o_id_err = id_err_q;
`else
    logic unused_exp_id;
    assign unused_exp_id = ^EXP_ID;
    assign o_id_err      = 1'b0;
`endif

endmodule
